rca_pipe_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder and the next generation of the team's 4-bit combinational RCA. It adds two WIDTH-bit operands plus carry-in. The work is split into STAGES chunks of CHUNK = WIDTH/STAGES bits, and each chunk is resolved in its own register stage. It has valid/ready handshakes on both sides, full backpressure, throughput of one add per cycle, and signed-overflow detection. It sits between operand-producing datapath blocks and result consumers where a full-width ripple chain would miss timing.

---
 rtl/rca_pkg.sv | 17 +
 rtl/rca_pipe_adder_chunk.sv | 26 ++
 rtl/rca_pipe_adder.sv | 148 ++++++++++++++
 tb/tb_rca_pipe_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: chunk sizing and the
// per-stage control record with its reset value.
package rca_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Control half of a stage record; the data half is sized per stage in the top.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_CTL_RST = '{valid: 1'b0, carry: 1'b0};

endpackage

// File: rtl/rca_pipe_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from a full-adder chain;
// also exposes the carry into its top bit for signed-overflow detection.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] X,
  input  logic [CHUNK-1:0] Y,
  input  logic             CI,
  output logic [CHUNK-1:0] S,
  output logic             CO,
  output logic             C_MSB
);

  logic [CHUNK:0] c;

  assign c[0] = CI;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign S[gi]   = X[gi] ^ Y[gi] ^ c[gi];
    assign c[gi+1] = (X[gi] & Y[gi]) | (c[gi] & (X[gi] ^ Y[gi]));
  end

  assign CO    = c[CHUNK];
  assign C_MSB = c[CHUNK-1];

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice resolved per register stage,
// valid/ready handshakes on both sides with full backpressure.
module rca_pipe_adder
  import rca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("rca_pipe_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * CHUNK;
    localparam int HI  = LO + CHUNK;
    localparam int REM = WIDTH - HI;

    stage_ctl_t       ctl_q, ctl_d;
    logic [HI-1:0]    sum_q, sum_d, sum_new;
    logic [CHUNK-1:0] x, y, s;
    logic             ci, co, c_msb;
    logic             up_valid, ready, take;

    if (gi == 0) begin : g_src
      assign up_valid = IN_VALID;
      assign x        = A[CHUNK-1:0];
      assign y        = B[CHUNK-1:0];
      assign ci       = CIN;
      assign sum_new  = s;
    end else begin : g_src
      // Upstream skew registers hold operand bits from chunk gi upwards.
      assign up_valid = g_stage[gi-1].ctl_q.valid;
      assign x        = g_stage[gi-1].g_skew.a_q[CHUNK-1:0];
      assign y        = g_stage[gi-1].g_skew.b_q[CHUNK-1:0];
      assign ci       = g_stage[gi-1].ctl_q.carry;
      assign sum_new  = {s, g_stage[gi-1].sum_q};
    end

    if (gi == STAGES - 1) begin : g_rdy
      assign ready = !ctl_q.valid || OUT_READY;
    end else begin : g_rdy
      assign ready = !ctl_q.valid || g_stage[gi+1].ready;
    end

    assign take = ready && up_valid;

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .X    (x),
      .Y    (y),
      .CI   (ci),
      .S    (s),
      .CO   (co),
      .C_MSB(c_msb)
    );

    always_comb begin
      ctl_d = ctl_q;
      sum_d = sum_q;
      if (ready) ctl_d.valid = up_valid;
      if (take) begin
        ctl_d.carry = co;
        sum_d       = sum_new;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        ctl_q <= STAGE_CTL_RST;
        sum_q <= '0;
      end else begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end

    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_q, a_d, b_q, b_d, a_src, b_src;

      if (gi == 0) begin : g_skew_src
        assign a_src = A[WIDTH-1:HI];
        assign b_src = B[WIDTH-1:HI];
      end else begin : g_skew_src
        assign a_src = g_stage[gi-1].g_skew.a_q[REM+CHUNK-1:CHUNK];
        assign b_src = g_stage[gi-1].g_skew.b_q[REM+CHUNK-1:CHUNK];
      end

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (take) begin
          a_d = a_src;
          b_d = b_src;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (gi == STAGES - 1) begin : g_last
      logic c_msb_q, c_msb_d;

      always_comb begin
        c_msb_d = c_msb_q;
        if (take) c_msb_d = c_msb;
      end

      always_ff @(posedge CLK) begin
        if (RST) c_msb_q <= 1'b0;
        else     c_msb_q <= c_msb_d;
      end
    end else begin : g_mid
      // Only the top chunk's MSB carry matters for overflow.
      logic c_msb_unused;
      assign c_msb_unused = c_msb;
    end
  end

  assign IN_READY  = g_stage[0].ready && !RST;
  assign OUT_VALID = g_stage[STAGES-1].ctl_q.valid;
  assign SUM       = g_stage[STAGES-1].sum_q;
  assign COUT      = g_stage[STAGES-1].ctl_q.carry;
  assign OVF       = g_stage[STAGES-1].g_last.c_msb_q ^ g_stage[STAGES-1].ctl_q.carry;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Self-checking bench for rca_pipe_adder (WIDTH=16, STAGES=4) with an
// arithmetic reference model and a FIFO scoreboard.
module tb_rca_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         OVF;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];

  localparam logic [W-1:0] TA [5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
  localparam logic [W-1:0] TB [5] = '{16'h4321, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000};
  localparam logic         TC [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [W+1:0] TE [5] = '{18'h05555, 18'h10000, 18'h1FFFF, 18'h28000, 18'h30000};

  rca_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .CIN      (CIN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .SUM      (SUM),
    .COUT     (COUT),
    .OVF      (OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang want finish");
    $fatal(1, "watchdog");
  end

  // {OVF, COUT, SUM} from plain integer addition and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  // One clock: note handshakes against current inputs, then advance to 1ns past the edge.
  task automatic cycle(output bit acc, output bit drn, output logic [W+1:0] obs,
                       output logic [W+1:0] expv);
    #1;
    acc  = IN_VALID && IN_READY;
    drn  = OUT_VALID && OUT_READY;
    obs  = {OVF, COUT, SUM};
    expv = 'x;
    if (drn && exp_q.size() > 0) expv = exp_q.pop_front();
    if (acc) exp_q.push_back(model(A, B, CIN));
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_beat();
    A   = W'($urandom);
    B   = W'($urandom);
    CIN = 1'($urandom);
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", IN_READY); end
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", OUT_VALID); end
    total++; if ({OVF, COUT, SUM} !== 18'h0) begin bad++; $display("FAIL rst_outputs: got %h want 00000", {OVF, COUT, SUM}); end
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", IN_READY); end
    exp_q.delete();
  endtask

  task automatic test_latency();
    bit acc, drn; logic [W+1:0] obs, expv; int lat;
    A = 16'h1234; B = 16'h4321; CIN = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    cycle(acc, drn, obs, expv);
    total++; if (!acc) begin bad++; $display("FAIL lat_accept: got %b want 1", acc); end
    IN_VALID = 1'b0;
    lat = 0;
    while (!OUT_VALID && lat < 10) begin cycle(acc, drn, obs, expv); lat++; end
    total++; if (lat != S - 1) begin bad++; $display("FAIL lat_edges: got %0d want %0d", lat, S - 1); end
    cycle(acc, drn, obs, expv);
    total++; if (!drn || obs !== 18'h05555) begin bad++; $display("FAIL lat_result: got drn=%b %h want 1 05555", drn, obs); end
  endtask

  task automatic test_directed();
    bit acc, drn; logic [W+1:0] obs, expv; int n;
    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      A = TA[i]; B = TB[i]; CIN = TC[i]; IN_VALID = 1'b1;
      cycle(acc, drn, obs, expv);
      IN_VALID = 1'b0;
      drn = 1'b0; n = 0;
      while (!drn && n < 20) begin cycle(acc, drn, obs, expv); n++; end
      total++; if (!drn) begin bad++; $display("FAIL dir_timeout[%0d]: got none want result", i); end
      total++; if (obs !== TE[i]) begin bad++; $display("FAIL dir_value[%0d]: got %h want %h", i, obs, TE[i]); end
      total++; if (obs !== expv) begin bad++; $display("FAIL dir_model[%0d]: got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_backpressure();
    bit acc, drn; logic [W+1:0] obs, expv, hold;
    logic [W-1:0] ba[6], bb[6]; logic bc[6];
    int idx, changes, drains, gaps;
    for (int i = 0; i < 6; i++) begin ba[i] = W'($urandom); bb[i] = W'($urandom); bc[i] = 1'($urandom); end
    OUT_READY = 1'b0; idx = 0;
    A = ba[0]; B = bb[0]; CIN = bc[0]; IN_VALID = 1'b1;
    repeat (8) begin
      cycle(acc, drn, obs, expv);
      if (acc) idx++;
      if (idx < 6) begin A = ba[idx]; B = bb[idx]; CIN = bc[idx]; end
    end
    total++; if (idx != S) begin bad++; $display("FAIL bp_accepted: got %0d want %0d", idx, S); end
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", IN_READY); end
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", OUT_VALID); end
    hold = {OVF, COUT, SUM};
    total++; if (hold !== model(ba[0], bb[0], bc[0])) begin bad++; $display("FAIL bp_head: got %h want %h", hold, model(ba[0], bb[0], bc[0])); end
    changes = 0;
    repeat (3) begin cycle(acc, drn, obs, expv); if ({OVF, COUT, SUM} !== hold || !OUT_VALID) changes++; end
    total++; if (changes != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", changes); end
    OUT_READY = 1'b1; drains = 0; gaps = 0;
    for (int c = 0; c < 20 && drains < 6; c++) begin
      cycle(acc, drn, obs, expv);
      if (acc) idx++;
      if (idx < 6) begin A = ba[idx]; B = bb[idx]; CIN = bc[idx]; end
      else IN_VALID = 1'b0;
      if (drn) begin
        drains++;
        total++; if (obs !== expv) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", drains, obs, expv); end
      end else gaps++;
    end
    total++; if (drains != 6) begin bad++; $display("FAIL bp_drains: got %0d want 6", drains); end
    total++; if (gaps != 0) begin bad++; $display("FAIL bp_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_back_to_back();
    bit acc, drn; logic [W+1:0] obs, expv; int sent, drains, calls, gaps;
    OUT_READY = 1'b1; sent = 0; drains = 0; calls = 0; gaps = 0;
    rand_beat(); IN_VALID = 1'b1;
    while (drains < 20 && calls < 60) begin
      cycle(acc, drn, obs, expv);
      calls++;
      if (acc) begin sent++; if (sent < 20) rand_beat(); else IN_VALID = 1'b0; end
      if (drn) begin
        drains++;
        total++; if (obs !== expv) begin bad++; $display("FAIL b2b_value[%0d]: got %h want %h", drains, obs, expv); end
      end else if (drains > 0) gaps++;
    end
    total++; if (gaps != 0) begin bad++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
    total++; if (calls != 20 + S) begin bad++; $display("FAIL b2b_cycles: got %0d want %0d", calls, 20 + S); end
  endtask

  task automatic test_reset_mid();
    bit acc, drn; logic [W+1:0] obs, expv; int spurious;
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    repeat (3) begin rand_beat(); cycle(acc, drn, obs, expv); end
    IN_VALID = 1'b0; RST = 1'b1;
    cycle(acc, drn, obs, expv);
    RST = 1'b0;
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", OUT_VALID); end
    total++; if ({OVF, COUT, SUM} !== 18'h0) begin bad++; $display("FAIL mid_rst_outputs: got %h want 00000", {OVF, COUT, SUM}); end
    exp_q.delete();
    OUT_READY = 1'b1; spurious = 0;
    repeat (10) begin cycle(acc, drn, obs, expv); if (drn) spurious++; end
    total++; if (spurious != 0) begin bad++; $display("FAIL mid_rst_stale: got %0d beats want 0", spurious); end
  endtask

  task automatic test_soak();
    bit acc, drn; logic [W+1:0] obs, expv; int sent, recv, iter;
    sent = 0; recv = 0; iter = 0;
    rand_beat(); IN_VALID = 1'($urandom);
    while ((sent < 512 || exp_q.size() > 0) && iter < 20000) begin
      OUT_READY = ($urandom_range(0, 9) < 7);
      cycle(acc, drn, obs, expv);
      iter++;
      if (acc) sent++;
      if (acc || !IN_VALID) begin
        rand_beat();
        IN_VALID = (sent < 512) ? 1'($urandom) : 1'b0;
      end
      if (drn) begin
        recv++;
        total++; if (obs !== expv) begin bad++; $display("FAIL soak[%0d]: got %h want %h", recv, obs, expv); end
      end
    end
    IN_VALID = 1'b0;
    total++; if (recv != 512 || sent != 512) begin bad++; $display("FAIL soak_count: got in=%0d out=%0d want 512/512", sent, recv); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
